// File: rtl/bitfield_unit.sv
// bitfield_unit: two-stage EXT/INS bitfield execution unit.
// Stage 1 aligns rs and builds the mask; stage 2 applies it.
module bitfield_unit #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  input  logic [4:0]       in_lsb,
  input  logic [4:0]       in_msbd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             op;
    logic [31:0]      aligned;
    logic [31:0]      mask;
    logic [31:0]      rt;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic        s1_valid;
  s1_t         s1_q;
  s1_t         s1_d;
  logic        s1_advance;
  logic        accept;
  logic [31:0] hi_mask;
  logic [31:0] lo_mask;
  logic [31:0] s2_res;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready && !flush;

  // Align operand; hi covers [msbd:0], lo covers [31:lsb].
  // For INS, msb < lsb makes hi & lo empty, leaving rt intact.
  always_comb begin
    hi_mask    = 32'hFFFF_FFFF >> (5'd31 - in_msbd);
    lo_mask    = 32'hFFFF_FFFF << in_lsb;
    s1_d.op    = in_op;
    s1_d.rt    = in_rt;
    s1_d.tag   = in_tag;
    if (in_op) begin
      s1_d.aligned = in_rs << in_lsb;
      s1_d.mask    = hi_mask & lo_mask;
    end else begin
      s1_d.aligned = in_rs >> in_lsb;
      s1_d.mask    = hi_mask;
    end
  end

  // Apply the mask: zero-extend for EXT, merge into rt for INS.
  always_comb begin
    if (s1_q.op)
      s2_res = (s1_q.rt & ~s1_q.mask)
             | (s1_q.aligned & s1_q.mask);
    else
      s2_res = s1_q.aligned & s1_q.mask;
  end

  // Stage 1 register: loads on accept, holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (flush)
        s1_valid <= 1'b0;
      else if (in_ready)
        s1_valid <= in_valid;
      if (accept)
        s1_q <= s1_d;
    end
  end

  // Stage 2 / output register: holds under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (s1_advance)
        out_valid <= s1_valid;
      if (!flush && s1_advance && s1_valid) begin
        out_result <= s2_res;
        out_tag    <= s1_q.tag;
      end
    end
  end

endmodule

// File: tb/tb_bitfield_unit.sv
// tb_bitfield_unit: directed vector bench for bitfield_unit.
// Table vectors plus backpressure, flush and reset sequences.
module tb_bitfield_unit;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_lsb;
  logic [4:0]  in_msbd;
  logic [5:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_tag;

  int nvec;
  int nerr;

  typedef struct {
    logic        op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  lsb;
    logic [4:0]  msbd;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[11];

  bitfield_unit #(.TAG_W(6)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_rs(in_rs),
    .in_rt(in_rt),
    .in_lsb(in_lsb),
    .in_msbd(in_msbd),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_op    = v.op;
    in_rs    = v.rs;
    in_rt    = v.rt;
    in_lsb   = v.lsb;
    in_msbd  = v.msbd;
    in_tag   = v.tag;
  endtask

  initial begin
    vec_t b1;
    vec_t b2;
    vec_t b3;
    nvec = 0;
    nerr = 0;
    vt[0]  = '{1'b0, 32'hDEADBEEF, 32'h0, 5'd8, 5'd7, 6'd1, 32'h000000BE};
    vt[1]  = '{1'b1, 32'h0, 32'hFFFFFFFF, 5'd4, 5'd11, 6'd2, 32'hFFFFF00F};
    vt[2]  = '{1'b1, 32'hAB, 32'h12345678, 5'd8, 5'd5, 6'd3, 32'h12345678};
    vt[3]  = '{1'b0, 32'hF0000000, 32'h0, 5'd28, 5'd7, 6'd4, 32'h0000000F};
    vt[4]  = '{1'b0, 32'h80000001, 32'h0, 5'd0, 5'd31, 6'd5, 32'h80000001};
    vt[5]  = '{1'b1, 32'hCAFEBABE, 32'h12345678, 5'd0, 5'd31, 6'd6, 32'hCAFEBABE};
    vt[6]  = '{1'b1, 32'h5, 32'h0, 5'd28, 5'd31, 6'd7, 32'h50000000};
    vt[7]  = '{1'b0, 32'h12345678, 32'h0, 5'd4, 5'd0, 6'd8, 32'h00000001};
    vt[8]  = '{1'b1, 32'h3, 32'hAAAAAAAA, 5'd0, 5'd0, 6'd9, 32'hAAAAAAAB};
    vt[9]  = '{1'b0, 32'hFFFFFFFF, 32'h0, 5'd31, 5'd31, 6'd10, 32'h00000001};
    vt[10] = '{1'b1, 32'h1234, 32'hFFFF0000, 5'd4, 5'd19, 6'd11, 32'hFFF12340};
    b1 = vt[0];
    b2 = '{1'b0, 32'h0000ABCD, 32'h0, 5'd0, 5'd15, 6'd2, 32'h0000ABCD};
    b3 = '{1'b1, 32'hF, 32'h0, 5'd8, 5'd11, 6'd3, 32'h00000F00};

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_rs     = '0;
    in_rt     = '0;
    in_lsb    = '0;
    in_msbd   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_tag", 32'(out_tag), 32'h0);
    reset_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 11; i++) begin
      drive(vt[i]);
      step();
      in_valid = 1'b0;
      check($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 32'h0);
      step();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("v%0d_result", i), out_result, vt[i].exp);
      check($sformatf("v%0d_tag", i), 32'(out_tag), 32'(vt[i].tag));
    end
    step();

    out_ready = 1'b0;
    drive(b1);
    #1;
    check("bp_rdy_t1", 32'(in_ready), 32'h1);
    step();
    drive(b2);
    #1;
    check("bp_rdy_t2", 32'(in_ready), 32'h1);
    step();
    drive(b3);
    #1;
    check("bp_rdy_t3", 32'(in_ready), 32'h0);
    check("bp_hold_tag_a", 32'(out_tag), 32'h1);
    step();
    check("bp_hold_valid", 32'(out_valid), 32'h1);
    check("bp_hold_tag_b", 32'(out_tag), 32'h1);
    check("bp_hold_result", out_result, b1.exp);
    check("bp_rdy_still0", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_release", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    check("bp_t2_valid", 32'(out_valid), 32'h1);
    check("bp_t2_tag", 32'(out_tag), 32'h2);
    check("bp_t2_result", out_result, b2.exp);
    step();
    check("bp_t3_valid", 32'(out_valid), 32'h1);
    check("bp_t3_tag", 32'(out_tag), 32'h3);
    check("bp_t3_result", out_result, b3.exp);
    step();
    check("bp_drained", 32'(out_valid), 32'h0);

    out_ready = 1'b0;
    b1.tag = 6'd4;
    drive(b1);
    step();
    b1.tag = 6'd5;
    drive(b1);
    step();
    check("fl_full_valid", 32'(out_valid), 32'h1);
    check("fl_full_rdy", 32'(in_ready), 32'h0);
    flush = 1'b1;
    out_ready = 1'b1;
    b1.tag = 6'd6;
    drive(b1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("fl_valid", 32'(out_valid), 32'h0);
    check("fl_rdy", 32'(in_ready), 32'h1);
    step();
    check("fl_drop_a", 32'(out_valid), 32'h0);
    step();
    check("fl_drop_b", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    drive(vt[3]);
    step();
    in_valid = 1'b0;
    check("fl_new_lat1", 32'(out_valid), 32'h0);
    step();
    check("fl_new_valid", 32'(out_valid), 32'h1);
    check("fl_new_result", out_result, vt[3].exp);
    check("fl_new_tag", 32'(out_tag), 32'(vt[3].tag));
    step();

    out_ready = 1'b0;
    drive(vt[4]);
    step();
    drive(vt[5]);
    step();
    in_valid = 1'b0;
    check("rs_full_valid", 32'(out_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rs_mid_valid", 32'(out_valid), 32'h0);
    check("rs_mid_result", out_result, 32'h0);
    check("rs_mid_tag", 32'(out_tag), 32'h0);
    check("rs_mid_rdy", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    check("rs_rel_rdy", 32'(in_ready), 32'h1);
    check("rs_rel_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rs_nostale%0d", k), 32'(out_valid), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
